// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: default bus geometry and the cache FSM state encoding.
// The cpu and the cache testbench both use these defaults.
package mem_pkg;

  localparam int ADDR_W_DEF       = 11;
  localparam int INDEX_W_DEF      = 4;
  localparam int OFFSET_W_DEF     = 2;
  localparam int MISS_LATENCY_DEF = 4;
  localparam int CNT_W_DEF        = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_REFILL  = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

endpackage

// File: rtl/cache_ctrl_tag_store.sv
// Tag array plus per-line valid bits for the direct-mapped cache.
// Combinational read on index, one write port, synchronous flush of all valid bits.
module tag_store #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) tag_q[wr_index_i] <= wr_tag_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid_q             <= '0;
    else if (flush_i) valid_q             <= '0;
    else if (wr_en_i) valid_q[wr_index_i] <= 1'b1;
  end

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped cache lookup engine: one request per handshake, hit/miss classification,
// fixed-latency refill on a miss, single-cycle response pulse and saturating statistics.
module cache_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int INDEX_W      = INDEX_W_DEF,
  parameter int OFFSET_W     = OFFSET_W_DEF,
  parameter int MISS_LATENCY = MISS_LATENCY_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              busy,
  output state_e            dbg_state
);

  // Handshake: a request transfers at a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE without flush. Responses have no backpressure.

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int RCNT_W = $clog2(MISS_LATENCY + 1);
  localparam logic [RCNT_W-1:0] REFILL_LOAD = RCNT_W'(MISS_LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [RCNT_W-1:0]   rcnt_q;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                resp_valid_q, resp_hit_q;
  logic [ADDR_W-1:0]   resp_addr_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [TAG_W-1:0]    store_tag;
  logic                store_valid;
  logic                lookup_hit;
  logic                store_flush;
  logic                refill_wr;
  logic                accept;

  assign addr_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign addr_index  = addr_q[OFFSET_W +: INDEX_W];
  assign lookup_hit  = store_valid && (store_tag == addr_tag);
  assign store_flush = (state_q == S_IDLE) && flush;
  assign refill_wr   = (state_q == S_REFILL) && (rcnt_q == '0);

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  assign hit_cnt_d  = (hit_cnt_q  == CNT_MAX) ? hit_cnt_q  : hit_cnt_q  + 1'b1;
  assign miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + 1'b1;

  tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (store_flush),
    .rd_index_i (addr_index),
    .rd_tag_o   (store_tag),
    .rd_valid_o (store_valid),
    .wr_en_i    (refill_wr),
    .wr_index_i (addr_index),
    .wr_tag_i   (addr_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rcnt_q       <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_addr_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            hit_cnt_q    <= hit_cnt_d;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_addr_q  <= addr_q;
            state_q      <= S_RESPOND;
          end else begin
            miss_cnt_q <= miss_cnt_d;
            rcnt_q     <= REFILL_LOAD;
            state_q    <= S_REFILL;
          end
        end
        S_REFILL: begin
          // The tag write happens in the same cycle via refill_wr.
          if (rcnt_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_addr_q  <= addr_q;
            state_q      <= S_RESPOND;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_addr  = resp_addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule
